hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Purpose : per-register RAW/WAW hazard scoreboard for an in-order issue stage; each
//           register carries a down-counter of cycles until its result is forwardable.
// Latency : stall/busy/pending_count are combinational from current counters; counter
//           updates and stall_cycles land on the next rising clk edge.
// Backpr. : stall tells decode to hold the presented instruction; nothing is accepted
//           while stall or flush is high.
// Ports   : clk/rst_n (async active-low); src_a/src_b addr+used, issue_* describe the
//           instruction in decode; flush drops all tracking; outputs stall, busy[NREG],
//           pending_count (popcount of busy), stall_cycles (saturating 16-bit).
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int LW      = 3,
    parameter int MAX_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   src_a_addr,
    input  logic            src_a_used,
    input  logic [AW-1:0]   src_b_addr,
    input  logic            src_b_used,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_waddr,
    input  logic [LW-1:0]   issue_lat,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     pending_count,
    output logic [15:0]     stall_cycles
);

    localparam logic [LW-1:0] MAX_L = LW'(MAX_LAT);

    logic [LW-1:0] cnt [NREG];

    logic [LW-1:0] eff_lat;
    logic [LW-1:0] cnt_a;
    logic [LW-1:0] cnt_b;
    logic [LW-1:0] cnt_w;
    logic          raw_a;
    logic          raw_b;
    logic          waw;
    logic          accept;

    // Counter lookup; register 0 and addresses beyond NREG always read as idle.
    function automatic logic [LW-1:0] cnt_of(input logic [AW-1:0] addr);
        logic [LW-1:0] val;
        val = '0;
        for (int r = 1; r < NREG; r++) begin
            if (addr == AW'(r)) val = cnt[r];
        end
        return val;
    endfunction

    always_comb begin
        eff_lat = (issue_lat > MAX_L) ? MAX_L : issue_lat;
        cnt_a   = cnt_of(src_a_addr);
        cnt_b   = cnt_of(src_b_addr);
        cnt_w   = cnt_of(issue_waddr);
        raw_a   = src_a_used & (src_a_addr != '0) & (cnt_a != '0);
        raw_b   = src_b_used & (src_b_addr != '0) & (cnt_b != '0);
        // A younger write may issue once the older result lands no later than ours.
        waw     = issue_we & (issue_waddr != '0) & (cnt_w > eff_lat);
        // Flush does not mask stall: decode still sees the hazard this cycle.
        stall   = issue_valid & (raw_a | raw_b | waw);
        accept  = issue_valid & ~stall & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0 || flush) begin
                    cnt[r] <= '0;
                end else if (accept && issue_we && issue_waddr == AW'(r)) begin
                    cnt[r] <= eff_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        pending_count = '0;
        for (int r = 0; r < NREG; r++) begin
            busy[r]       = (cnt[r] != '0);
            pending_count = pending_count + (AW+1)'(busy[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (issue_valid && stall && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose : self-checking bench for hazard_scoreboard: directed vector table, async
//           reset mid-operation, randomized traffic against a ready-time model, and
//           stall_cycles saturation.
module tb_hazard_scoreboard;

    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int LW      = 3;
    localparam int MAX_LAT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   src_a_addr;
    logic            src_a_used;
    logic [AW-1:0]   src_b_addr;
    logic            src_b_used;
    logic            issue_valid;
    logic            issue_we;
    logic [AW-1:0]   issue_waddr;
    logic [LW-1:0]   issue_lat;
    logic            flush;
    logic            stall;
    logic [NREG-1:0] busy;
    logic [AW:0]     pending_count;
    logic [15:0]     stall_cycles;

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .LW(LW), .MAX_LAT(MAX_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_a_addr    (src_a_addr),
        .src_a_used    (src_a_used),
        .src_b_addr    (src_b_addr),
        .src_b_used    (src_b_used),
        .issue_valid   (issue_valid),
        .issue_we      (issue_we),
        .issue_waddr   (issue_waddr),
        .issue_lat     (issue_lat),
        .flush         (flush),
        .stall         (stall),
        .busy          (busy),
        .pending_count (pending_count),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each register remembers the absolute cycle at which its
    // result becomes forwardable; it is pending while that time is in the future.
    longint now = 0;
    longint rdy_t [NREG];
    int     sc_m = 0;

    function automatic int rem(input int r);
        if (r <= 0 || r >= NREG) return 0;
        if (rdy_t[r] > now) return int'(rdy_t[r] - now);
        return 0;
    endfunction

    function automatic int eff();
        return (int'(issue_lat) > MAX_LAT) ? MAX_LAT : int'(issue_lat);
    endfunction

    function automatic bit model_stall();
        bit ra, rb, ww;
        ra = src_a_used && rem(int'(src_a_addr)) != 0;
        rb = src_b_used && rem(int'(src_b_addr)) != 0;
        ww = issue_we && rem(int'(issue_waddr)) > eff();
        return issue_valid && (ra || rb || ww);
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        for (int r = 0; r < NREG; r++) b[r] = (rem(r) != 0);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] b;
        b = model_busy();
        chk("model_stall", 32'(stall), 32'(model_stall()));
        chk("model_busy", busy, b);
        chk("model_pcount", 32'(pending_count), 32'($countones(b)));
        chk("model_stall_cycles", 32'(stall_cycles), 32'(sc_m));
    endtask

    task automatic set_in(input bit v, input bit we, input int wa, input int lat,
                          input bit ua, input int a, input bit ub, input int b, input bit fl);
        issue_valid = v;
        issue_we    = we;
        issue_waddr = AW'(wa);
        issue_lat   = LW'(lat);
        src_a_used  = ua;
        src_a_addr  = AW'(a);
        src_b_used  = ub;
        src_b_addr  = AW'(b);
        flush       = fl;
    endtask

    // One clock: optional model check before the edge, model update at the edge.
    task automatic step(input bit do_chk);
        bit s;
        int e;
        #1;
        s = model_stall();
        e = eff();
        if (do_chk) check_model();
        @(posedge clk);
        if (issue_valid && s && sc_m < 65535) sc_m++;
        if (flush) begin
            for (int r = 0; r < NREG; r++) rdy_t[r] = now;
        end else if (issue_valid && !s && issue_we && issue_waddr != '0) begin
            rdy_t[int'(issue_waddr)] = now + 1 + e;
        end
        now++;
        @(negedge clk);
    endtask

    typedef struct {
        bit          v, we;
        int          wa, lat;
        bit          ua;
        int          a;
        bit          ub;
        int          b;
        bit          fl;
        bit          e_stall;
        int          e_pc;
        logic [31:0] e_busy;
        int          e_sc;
    } vec_t;

    vec_t tv [$];

    function automatic vec_t mk(input bit v, input bit we, input int wa, input int lat,
                                input bit ua, input int a, input bit ub, input int b,
                                input bit fl, input bit es, input int epc,
                                input logic [31:0] eb, input int esc);
        vec_t t;
        t.v = v; t.we = we; t.wa = wa; t.lat = lat; t.ua = ua; t.a = a;
        t.ub = ub; t.b = b; t.fl = fl; t.e_stall = es; t.e_pc = epc;
        t.e_busy = eb; t.e_sc = esc;
        return t;
    endfunction

    initial begin
        int rounds;
        for (int r = 0; r < NREG; r++) rdy_t[r] = 0;
        rst_n = 1'b0;
        set_in(1, 0, 0, 0, 1, 8, 1, 9, 0);
        #2;
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_busy", busy, 32'h0);
        chk("reset_pcount", 32'(pending_count), 32'h0);
        chk("reset_stall_cycles", 32'(stall_cycles), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //            v we wa lat ua a ub b fl | stall pc busy        sc
        // load-use
        tv.push_back(mk(1,1, 8,2, 0,0, 0,0, 0,   0, 0, 32'h0,       0));
        tv.push_back(mk(1,0, 0,0, 1,8, 0,0, 0,   1, 1, 32'h100,     0));
        tv.push_back(mk(1,0, 0,0, 1,8, 0,0, 0,   1, 1, 32'h100,     1));
        tv.push_back(mk(1,0, 0,0, 1,8, 0,0, 0,   0, 0, 32'h0,       2));
        // $zero destination/source and unused sources
        tv.push_back(mk(1,1, 0,4, 0,0, 0,0, 0,   0, 0, 32'h0,       2));
        tv.push_back(mk(1,1, 8,4, 0,0, 0,0, 0,   0, 0, 32'h0,       2));
        tv.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,   0, 1, 32'h100,     2));
        tv.push_back(mk(1,0, 0,0, 1,0, 0,8, 0,   0, 1, 32'h100,     2));
        tv.push_back(mk(0,0, 0,0, 1,8, 1,8, 0,   0, 1, 32'h100,     2));
        tv.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,   0, 1, 32'h100,     2));
        tv.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,   0, 0, 32'h0,       2));
        // WAW with latency clamp
        tv.push_back(mk(1,1, 5,7, 0,0, 0,0, 0,   0, 0, 32'h0,       2));
        tv.push_back(mk(1,1, 5,1, 0,0, 0,0, 0,   1, 1, 32'h20,      2));
        tv.push_back(mk(1,1, 5,1, 0,0, 0,0, 0,   1, 1, 32'h20,      3));
        tv.push_back(mk(1,1, 5,1, 0,0, 0,0, 0,   1, 1, 32'h20,      4));
        tv.push_back(mk(1,1, 5,1, 0,0, 0,0, 0,   0, 1, 32'h20,      5));
        tv.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,   0, 1, 32'h20,      5));
        tv.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,   0, 0, 32'h0,       5));
        // flush beats simultaneous issue
        tv.push_back(mk(1,1, 3,4, 0,0, 0,0, 0,   0, 0, 32'h0,       5));
        tv.push_back(mk(1,1, 4,4, 0,0, 0,0, 0,   0, 1, 32'h8,       5));
        tv.push_back(mk(1,1, 9,4, 0,0, 0,0, 0,   0, 2, 32'h18,      5));
        tv.push_back(mk(1,1,10,3, 0,0, 0,0, 1,   0, 3, 32'h218,     5));
        tv.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,   0, 0, 32'h0,       5));
        // stall still visible (and counted) during flush
        tv.push_back(mk(1,1, 8,3, 0,0, 0,0, 0,   0, 0, 32'h0,       5));
        tv.push_back(mk(1,0, 0,0, 1,8, 0,0, 1,   1, 1, 32'h100,     5));
        tv.push_back(mk(1,0, 0,0, 1,8, 0,0, 0,   0, 0, 32'h0,       6));

        foreach (tv[i]) begin
            set_in(tv[i].v, tv[i].we, tv[i].wa, tv[i].lat, tv[i].ua, tv[i].a,
                   tv[i].ub, tv[i].b, tv[i].fl);
            #1;
            chk($sformatf("tv%0d_stall", i), 32'(stall), 32'(tv[i].e_stall));
            chk($sformatf("tv%0d_pcount", i), 32'(pending_count), 32'(tv[i].e_pc));
            chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
            chk($sformatf("tv%0d_stall_cycles", i), 32'(stall_cycles), 32'(tv[i].e_sc));
            step(1);
        end

        // Asynchronous reset between edges with four registers pending.
        for (int r = 1; r <= 4; r++) begin
            set_in(1, 1, r, 4, 0, 0, 0, 0, 0);
            step(1);
        end
        set_in(1, 0, 0, 0, 1, 4, 0, 0, 0);
        #1;
        check_model();
        chk("pre_reset_pcount", 32'(pending_count), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'h0);
        chk("arst_busy", busy, 32'h0);
        chk("arst_pcount", 32'(pending_count), 32'h0);
        chk("arst_stall_cycles", 32'(stall_cycles), 32'h0);
        for (int r = 0; r < NREG; r++) rdy_t[r] = now;
        sc_m = 0;
        @(posedge clk);
        now++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // Randomized traffic; small address range to provoke frequent hazards.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 9),
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 9),
                   $urandom_range(0, 1), $urandom_range(0, 9), ($urandom_range(0, 19) == 0));
            step(1);
        end

        // Saturation: producer on r8 then four dependent stall cycles, repeated.
        rounds = (65540 - sc_m) / 4 + 1;
        if (rounds < 1) rounds = 1;
        for (int i = 0; i < rounds; i++) begin
            set_in(1, 1, 8, 4, 0, 0, 0, 0, 0);
            step(0);
            for (int k = 0; k < 4; k++) begin
                set_in(1, 0, 0, 0, 1, 8, 0, 0, 0);
                step(0);
            end
        end
        set_in(1, 1, 8, 4, 0, 0, 0, 0, 0);
        #1;
        chk("sat_stall_cycles", 32'(stall_cycles), 32'hFFFF);
        check_model();
        step(0);
        set_in(1, 0, 0, 0, 1, 8, 0, 0, 0);
        step(0);
        step(1);
        chk("sat_no_wrap", 32'(stall_cycles), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
